// File: rtl/hdlc_pkg.sv
// Shared HDLC receive definitions: flag byte, FSM states, raw-bit classes.
package hdlc_pkg;
  localparam logic [7:0] HDLC_FLAG = 8'h7E;
  localparam int PAYLOAD_BYTES_DEF = 6;

  typedef enum logic {HUNT, RECV} state_e;
  typedef enum logic [1:0] {BIT_DATA, BIT_STUFF, BIT_FLAG, BIT_ABORT} bit_class_e;
endpackage

// File: rtl/hdlc_unstuff.sv
// Raw line-bit classifier: counts consecutive 1s and tags each bit as data/stuff/flag/abort.
// HDLC_RX_SYNC_EN inserts a 2-flop synchronizer (idle-high reset) ahead of classification.
module hdlc_unstuff
  import hdlc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output bit_class_e cls,
  output logic       dbit
);
  logic       rxs;
  logic [2:0] ones_cnt;

`ifdef HDLC_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end
  assign rxs = sync[1];
`else
  assign rxs = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst)                  ones_cnt <= '0;
    else if (!rxs)            ones_cnt <= '0;
    else if (ones_cnt != 3'd7) ones_cnt <= ones_cnt + 3'd1;
  end

  // classification uses the run length before this bit is folded in
  always_comb begin
    cls = BIT_DATA;
    if (ones_cnt == 3'd5 && !rxs)      cls = BIT_STUFF;
    else if (ones_cnt == 3'd6 && !rxs) cls = BIT_FLAG;
    else if (ones_cnt >= 3'd6 && rxs)  cls = BIT_ABORT;
  end

  assign dbit = rxs;
endmodule

// File: rtl/hdlc_recvdata.sv
// HDLC receiver: flag hunt, payload assembly and re-framing as {7E, payload, 7E}.
// Optional input synchronizer selected by HDLC_RX_SYNC_EN (see hdlc_unstuff).
module hdlc_recvdata
  import hdlc_pkg::*;
#(
  parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [8*PAYLOAD_BYTES+15:0]  data,
  output logic                         is_recv,
  output logic                         frame_err
);
  localparam int AW = 8*PAYLOAD_BYTES + 7;
  localparam int CW = $clog2(8*PAYLOAD_BYTES + 9);
  localparam logic [CW-1:0] CNT_MAX  = CW'(8*PAYLOAD_BYTES + 8);
  localparam logic [CW-1:0] CNT_IDLE = CW'(7);
  localparam logic [CW-1:0] CNT_FULL = CW'(AW);

  bit_class_e     cls;
  logic           dbit;
  state_e         state_q, state_d;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  bit_cnt;
  logic           recv_d, err_d;

  hdlc_unstuff u_unstuff (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .cls  (cls),
    .dbit (dbit)
  );

  // acc/bit_cnt run in both states; HUNT simply never looks at them, and
  // the leading 7 flag bits land in acc[6:0] and are dropped on the flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (cls == BIT_DATA) begin
      acc <= {acc[AW-2:0], dbit};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
    end else if (cls == BIT_FLAG) begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (cls == BIT_FLAG)  state_d = RECV;
      RECV:    if (cls == BIT_ABORT) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    recv_d = 1'b0;
    err_d  = 1'b0;
    if (state_q == RECV) begin
      if (cls == BIT_FLAG) begin
        if (bit_cnt == CNT_FULL)      recv_d = 1'b1;
        else if (bit_cnt != CNT_IDLE) err_d  = 1'b1;
      end else if (cls == BIT_ABORT) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      is_recv   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      is_recv   <= recv_d;
      frame_err <= err_d;
      if (recv_d) data <= {HDLC_FLAG, acc[AW-1:7], HDLC_FLAG};
    end
  end
endmodule

// File: tb/tb_hdlc_recvdata.sv
// Self-checking bench: builds a line stream from frame-level segments and
// records, per line bit, the pulse and held data the receiver must show.
module tb_hdlc_recvdata;
  localparam int EV_NONE = 0;
  localparam int EV_RECV = 1;
  localparam int EV_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [63:0] data;
  logic        is_recv, frame_err;

  hdlc_recvdata dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .is_recv   (is_recv),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // expected stream: one entry per line bit
  bit          qbit[$];
  bit          qrst[$];
  int          qev[$];
  logic [63:0] qdat[$];
  int          qpos = 0;

  bit          m_recv = 1'b0;
  logic [63:0] m_data = '0;
  int          m_run  = 0;

  int  nchk = 0, nerr = 0;
  int  n_recv = 0, n_err = 0;
  int  sidx = 0;
  bit  active = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at bit %0d: got %h expected %h", name, sidx, act, exp);
    end
  endtask

  task automatic push_bit(input bit b, input int ev, input logic [63:0] d);
    if (ev == EV_RECV) m_data = d;
    m_run = b ? m_run + 1 : 0;
    qbit.push_back(b);
    qrst.push_back(1'b0);
    qev.push_back(ev);
    qdat.push_back(m_data);
  endtask

  task automatic push_rst(input int n);
    m_data = '0;
    m_recv = 1'b0;
    m_run  = 0;
    for (int i = 0; i < n; i++) begin
      qbit.push_back(1'b1);
      qrst.push_back(1'b1);
      qev.push_back(EV_NONE);
      qdat.push_back(64'd0);
    end
  endtask

  task automatic add_flag(input int ev, input logic [63:0] d);
    push_bit(1'b0, EV_NONE, '0);
    for (int i = 0; i < 6; i++) push_bit(1'b1, EV_NONE, '0);
    push_bit(1'b0, ev, d);
  endtask

  task automatic add_idle_flag();
    add_flag(EV_NONE, '0);
    m_recv = 1'b1;
  endtask

  // reference zero-stuffer: a 0 after every run of five data 1s
  task automatic add_stuffed(input logic [47:0] pl, input int nbits);
    int run;
    run = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      push_bit(pl[i], EV_NONE, '0);
      run = pl[i] ? run + 1 : 0;
      if (run == 5) begin
        push_bit(1'b0, EV_NONE, '0);
        run = 0;
      end
    end
  endtask

  task automatic add_frame(input logic [47:0] pl, input int nbytes);
    if (!m_recv) add_idle_flag();
    add_stuffed(pl, 8*nbytes);
    if (nbytes == 6) add_flag(EV_RECV, {8'h7E, pl, 8'h7E});
    else             add_flag(EV_ERR, '0);
  endtask

  // n raw 1s; the seventh consecutive 1 is the abort point
  task automatic add_ones(input int n);
    bit was;
    was = m_recv;
    for (int i = 0; i < n; i++)
      push_bit(1'b1, (was && m_run + 1 == 7) ? EV_ERR : EV_NONE, '0);
    m_recv = 1'b0;
  endtask

  task automatic add_abort(input logic [47:0] pl, input int nbits);
    if (!m_recv) add_idle_flag();
    add_stuffed(pl, nbits);
    add_ones(8);
  endtask

  task automatic run_q();
    while (qpos < qbit.size()) begin
      rx     = qbit[qpos];
      rst    = qrst[qpos];
      sidx   = qpos;
      active = 1'b1;
      qpos++;
      @(negedge clk);
    end
    active = 1'b0;
  endtask

  function automatic logic [47:0] rnd_payload();
    logic [47:0] p;
    p = 48'({$urandom(), $urandom()});
    if ($urandom_range(0, 1) == 1) p = p | (48'hFFF << $urandom_range(0, 36));
    return p;
  endfunction

  always @(posedge clk) begin
    #1;
    if (active) begin
      chk("is_recv",   64'(is_recv),   64'(qev[sidx] == EV_RECV));
      chk("frame_err", 64'(frame_err), 64'(qev[sidx] == EV_ERR));
      chk("data",      data,           qdat[sidx]);
      if (is_recv)   n_recv++;
      if (frame_err) n_err++;
    end
  end

  initial begin
    logic [47:0] p;
    logic [63:0] keep;
    int r0, e0;

    @(negedge clk);
    // reset with idle line
    push_rst(5);
    run_q();
    chk("reset data", data, 64'd0);
    chk("reset pulses", 64'(n_recv + n_err), 64'd0);

    // plain frame, no stuffing needed
    r0 = n_recv; e0 = n_err;
    add_ones(10);
    add_frame(48'h000100111010, 6);
    run_q();
    chk("frame1 data", data, 64'h7E0001001110107E);
    chk("frame1 model", m_data, 64'h7E0001001110107E);
    chk("frame1 recv count", 64'(n_recv - r0), 64'd1);

    // payload that needs stuffing
    r0 = n_recv;
    add_frame(48'hFF7E3F000001, 6);
    run_q();
    chk("stuffed data", data, 64'h7EFF7E3F0000017E);
    chk("stuffed recv count", 64'(n_recv - r0), 64'd1);

    // idle flags then a frame
    r0 = n_recv; e0 = n_err;
    for (int i = 0; i < 3; i++) add_idle_flag();
    p = rnd_payload();
    add_frame(p, 6);
    run_q();
    keep = {8'h7E, p, 8'h7E};
    chk("idle flags data", data, keep);
    chk("idle flags recv count", 64'(n_recv - r0), 64'd1);
    chk("idle flags err count", 64'(n_err - e0), 64'd0);

    // short frame keeps prior data
    r0 = n_recv; e0 = n_err;
    add_frame(rnd_payload(), 5);
    run_q();
    chk("short err count", 64'(n_err - e0), 64'd1);
    chk("short recv count", 64'(n_recv - r0), 64'd0);
    chk("short data held", data, keep);

    // abort mid-payload, then recovery
    e0 = n_err; r0 = n_recv;
    add_abort(rnd_payload(), 20);
    run_q();
    chk("abort err count", 64'(n_err - e0), 64'd1);
    p = 48'h123456ABCDEF;
    add_frame(p, 6);
    run_q();
    chk("after abort data", data, 64'h7E123456ABCDEF7E);
    chk("after abort recv count", 64'(n_recv - r0), 64'd1);

    // reset mid-frame
    r0 = n_recv; e0 = n_err;
    add_idle_flag();
    add_stuffed(rnd_payload(), 24);
    push_rst(2);
    add_stuffed(rnd_payload(), 24);
    add_ones(10);
    run_q();
    chk("midrst pulses", 64'(n_recv - r0 + n_err - e0), 64'd0);
    chk("midrst data", data, 64'd0);

    // randomized segment mix
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: add_frame(rnd_payload(), 6);
        4:          add_frame(rnd_payload(), $urandom_range(4, 5));
        5:          add_idle_flag();
        6:          add_abort(rnd_payload(), $urandom_range(0, 47));
        7:          add_ones($urandom_range(8, 20));
        8:          begin
                      add_stuffed(rnd_payload(), $urandom_range(1, 40));
                      push_rst($urandom_range(1, 3));
                      add_ones(8);
                    end
        default:    add_frame(48'hFFFFFFFFFFFF, 6);
      endcase
    end
    run_q();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
